// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the hazard scheduler: RV32I opcodes, FSM states,
// the default NOP word and the decoded-hazard record carried down the shadow pipe.
package hazard_scheduler_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       writes_rd;
    logic       reads_rs1;
    logic       reads_rs2;
    logic       is_load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } hz_dec_t;

  // s2 keeps the full decode (it still has operands to forward into)
  typedef struct packed {
    logic    valid;
    hz_dec_t dec;
  } hz_s2_t;

  // s3 only needs the producer side
  typedef struct packed {
    logic       valid;
    logic       writes_rd;
    logic       is_load;
    logic [4:0] rd;
  } hz_s3_t;

endpackage

// File: rtl/hazard_scheduler_if.sv
// Datapath <-> hazard scheduler signal bundle.
// master: datapath side (drives instruction/status, consumes controls).
// slave : scheduler side.
interface hazard_scheduler_if;
  logic [31:0] inst_s1;
  logic        valid_s1;
  logic        redirect_s2;
  logic        mem_busy;
  logic        stall_pc;
  logic        bubble_s2;
  logic        flush_s1;
  logic        freeze;
  logic        byp_rs1_s1;
  logic        byp_rs2_s1;
  logic        fwd_rs1_s2;
  logic        fwd_rs2_s2;

  modport master (
    output inst_s1, valid_s1, redirect_s2, mem_busy,
    input  stall_pc, bubble_s2, flush_s1, freeze,
    input  byp_rs1_s1, byp_rs2_s1, fwd_rs1_s2, fwd_rs2_s2
  );

  modport slave (
    input  inst_s1, valid_s1, redirect_s2, mem_busy,
    output stall_pc, bubble_s2, flush_s1, freeze,
    output byp_rs1_s1, byp_rs2_s1, fwd_rs1_s2, fwd_rs2_s2
  );
endinterface

// File: rtl/hazard_scheduler_decode.sv
// inst_hazard_decode: pure combinational RV32I classifier producing the
// register read/write footprint the hazard logic needs.
module inst_hazard_decode
  import hazard_scheduler_pkg::*;
(
  input  logic [31:0] inst_i,
  output hz_dec_t     dec_o
);

  logic [6:0] opc;
  logic [2:0] funct3;

  assign opc    = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  // Classify the opcode into read/write/load classes
  always_comb begin
    dec_o           = '0;
    dec_o.rd        = inst_i[11:7];
    dec_o.rs1       = inst_i[19:15];
    dec_o.rs2       = inst_i[24:20];
    unique case (opc)
      OPC_OP: begin
        dec_o.writes_rd = 1'b1;
        dec_o.reads_rs1 = 1'b1;
        dec_o.reads_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_o.writes_rd = 1'b1;
        dec_o.reads_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        dec_o.writes_rd = 1'b1;
        dec_o.reads_rs1 = 1'b1;
        dec_o.is_load   = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        dec_o.reads_rs1 = 1'b1;
        dec_o.reads_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        dec_o.writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dec_o.writes_rd = 1'b1;
        dec_o.reads_rs1 = 1'b1;
      end
      OPC_SYSTEM: begin
        // funct3 000 is ECALL/EBREAK/xRET; 1xx are the immediate CSR forms
        dec_o.writes_rd = (funct3 != 3'b000);
        dec_o.reads_rs1 = (funct3 != 3'b000) && !funct3[2];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: stall/flush/forward sequencer for the 3-stage RV32I core.
// Tracks a shadow copy of the s2/s3 hazard info and issues bypass, forward,
// load-use stall, redirect flush and memory freeze controls.
// Optional performance counters: define HAZARD_PERF_CNT_EN.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_scheduler_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]    stall_cnt,
  output logic [PERF_W-1:0]    flush_cnt
`endif
);

  localparam logic [1:0] LU_BCNT_INIT = 2'(LU_BUBBLES - 1);

  hz_state_e  state_q, state_d;
  hz_state_e  ret_q, ret_d;
  hz_state_e  eff_state;
  logic [1:0] bcnt_q, bcnt_d;
  hz_s2_t     s2_q, s2_d;
  hz_s3_t     s3_q;

  hz_dec_t    dec_raw, dec_s1;
  logic       s1_rd1, s1_rd2;
  logic       load_use;
  logic       stall_c, bubble_c, flush_c, freeze_c;
  logic       byp1_c, byp2_c, fwd1_c, fwd2_c;

  inst_hazard_decode u_decode (
    .inst_i (hz.inst_s1),
    .dec_o  (dec_raw)
  );

  // Qualify the s1 decode: the injected NOP never produces a result
  always_comb begin
    dec_s1 = dec_raw;
    if (hz.inst_s1 == NOP_INST) dec_s1.writes_rd = 1'b0;
  end

  assign s1_rd1 = hz.valid_s1 && dec_s1.reads_rs1;
  assign s1_rd2 = hz.valid_s1 && dec_s1.reads_rs2;

  assign load_use = s2_q.valid && s2_q.dec.is_load && (s2_q.dec.rd != 5'd0) &&
                    ((s1_rd1 && (dec_s1.rs1 == s2_q.dec.rd)) ||
                     (s1_rd2 && (dec_s1.rs2 == s2_q.dec.rd)));

  // s1 regfile bypass from s3 writeback, and s2 ALU forward from a non-load s3 result
  always_comb begin
    byp1_c = s1_rd1 && s3_q.valid && s3_q.writes_rd &&
             (s3_q.rd == dec_s1.rs1) && (dec_s1.rs1 != 5'd0);
    byp2_c = s1_rd2 && s3_q.valid && s3_q.writes_rd &&
             (s3_q.rd == dec_s1.rs2) && (dec_s1.rs2 != 5'd0);
    fwd1_c = s2_q.valid && s2_q.dec.reads_rs1 && s3_q.valid && s3_q.writes_rd &&
             !s3_q.is_load && (s3_q.rd == s2_q.dec.rs1) && (s2_q.dec.rs1 != 5'd0);
    fwd2_c = s2_q.valid && s2_q.dec.reads_rs2 && s3_q.valid && s3_q.writes_rd &&
             !s3_q.is_load && (s3_q.rd == s2_q.dec.rs2) && (s2_q.dec.rs2 != 5'd0);
  end

  // Next-state and control outputs. MEM_WAIT resolves to its saved state in the
  // cycle mem_busy drops, so the freeze lasts exactly as long as mem_busy.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    bcnt_d   = bcnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    freeze_c = 1'b0;
    eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

    if (hz.mem_busy) begin
      freeze_c = 1'b1;
      state_d  = ST_MEM_WAIT;
      ret_d    = eff_state;
    end else begin
      unique case (eff_state)
        ST_LU_STALL: begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          bcnt_d   = bcnt_q - 2'd1;
          state_d  = (bcnt_q == 2'd1) ? ST_RUN : ST_LU_STALL;
        end
        default: begin
          state_d = ST_RUN;
          if (hz.redirect_s2) begin
            flush_c = 1'b1;
          end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (LU_BUBBLES > 1) begin
              bcnt_d  = LU_BCNT_INIT;
              state_d = ST_LU_STALL;
            end
          end
        end
      endcase
    end
  end

  // Next s2 shadow entry: bubble, or the s1 decode unless it is being flushed
  always_comb begin
    s2_d = '0;
    if (!bubble_c) begin
      s2_d.valid = hz.valid_s1 && !flush_c;
      s2_d.dec   = dec_s1;
    end
  end

  // FSM state, return state and bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Shadow pipeline advances with the same freeze/bubble/flush decisions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '0;
      s3_q <= '0;
    end else if (!freeze_c) begin
      s2_q           <= s2_d;
      s3_q.valid     <= s2_q.valid;
      s3_q.writes_rd <= s2_q.dec.writes_rd;
      s3_q.is_load   <= s2_q.dec.is_load;
      s3_q.rd        <= s2_q.dec.rd;
    end
  end

  // Inputs may be live during reset; keep every control quiet until released
  assign hz.stall_pc   = rst_n && stall_c;
  assign hz.bubble_s2  = rst_n && bubble_c;
  assign hz.flush_s1   = rst_n && flush_c;
  assign hz.freeze     = rst_n && freeze_c;
  assign hz.byp_rs1_s1 = rst_n && byp1_c;
  assign hz.byp_rs2_s1 = rst_n && byp2_c;
  assign hz.fwd_rs1_s2 = rst_n && fwd1_c;
  assign hz.fwd_rs2_s2 = rst_n && fwd2_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c || freeze_c) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_c)             flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: three instances with LU_BUBBLES = 1, 2, 3
// share one stimulus stream. Output vector order per instance:
// {stall_pc, bubble_s2, flush_s1, freeze, byp_rs1_s1, byp_rs2_s1, fwd_rs1_s2, fwd_rs2_s2}
module tb_hazard_scheduler;

  localparam logic [31:0] I_NOP     = 32'h0000_0013;
  localparam logic [31:0] I_ADD_X5  = 32'h0020_82B3; // add  x5,x1,x2
  localparam logic [31:0] I_SUB_X6  = 32'h4032_8333; // sub  x6,x5,x3
  localparam logic [31:0] I_LW_X5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADDI_X6 = 32'h0012_8313; // addi x6,x5,1
  localparam logic [31:0] I_ADDI_X0 = 32'h0010_8013; // addi x0,x1,1
  localparam logic [31:0] I_LW_X0   = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD_X7  = 32'h0000_03B3; // add  x7,x0,x0
  localparam logic [31:0] I_ADD_X8  = 32'h0000_0433; // add  x8,x0,x0

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        valid;
  logic        redirect;
  logic        busy;

  int unsigned checks;
  int unsigned errors;

  hazard_scheduler_if if1 ();
  hazard_scheduler_if if2 ();
  hazard_scheduler_if if3 ();

  assign if1.inst_s1 = inst;  assign if1.valid_s1 = valid;
  assign if1.redirect_s2 = redirect;  assign if1.mem_busy = busy;
  assign if2.inst_s1 = inst;  assign if2.valid_s1 = valid;
  assign if2.redirect_s2 = redirect;  assign if2.mem_busy = busy;
  assign if3.inst_s1 = inst;  assign if3.valid_s1 = valid;
  assign if3.redirect_s2 = redirect;  assign if3.mem_busy = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, sc2, sc3, fc1, fc2, fc3;
`endif

  hazard_scheduler #(.LU_BUBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hz(if1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );
  hazard_scheduler #(.LU_BUBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hz(if2)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
  );
  hazard_scheduler #(.LU_BUBBLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .hz(if3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  logic [7:0] o1, o2, o3;
  assign o1 = {if1.stall_pc, if1.bubble_s2, if1.flush_s1, if1.freeze,
               if1.byp_rs1_s1, if1.byp_rs2_s1, if1.fwd_rs1_s2, if1.fwd_rs2_s2};
  assign o2 = {if2.stall_pc, if2.bubble_s2, if2.flush_s1, if2.freeze,
               if2.byp_rs1_s1, if2.byp_rs2_s1, if2.fwd_rs1_s2, if2.fwd_rs2_s2};
  assign o3 = {if3.stall_pc, if3.bubble_s2, if3.flush_s1, if3.freeze,
               if3.byp_rs1_s1, if3.byp_rs2_s1, if3.fwd_rs1_s2, if3.fwd_rs2_s2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all three instances against their expected control vectors
  task automatic chk3(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                      input logic [7:0] e3);
    #1;
    chk({tag, "/lu1"}, {24'd0, o1}, {24'd0, e1});
    chk({tag, "/lu2"}, {24'd0, o2}, {24'd0, e2});
    chk({tag, "/lu3"}, {24'd0, o3}, {24'd0, e3});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    chk3("in_reset", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    inst     = I_NOP;
    valid    = 1'b0;
    redirect = 1'b0;
    busy     = 1'b0;

    // Reset state
    tick();
    do_reset();
    valid = 1'b1;
    chk3("post_reset", 8'h00, 8'h00, 8'h00);

    // add x5 -> sub x6,x5,x3: ALU forward on rs1 in the second cycle
    inst = I_ADD_X5;  chk3("alu_c0", 8'h00, 8'h00, 8'h00);  tick();
    inst = I_SUB_X6;  chk3("alu_c1", 8'h00, 8'h00, 8'h00);  tick();
    inst = I_NOP;     chk3("alu_fwd", 8'h02, 8'h02, 8'h02); tick();
    chk3("alu_c3", 8'h00, 8'h00, 8'h00); tick();

    // lw x5 -> addi x6,x5,1: 1/2/3 stall cycles, then s1 bypass
    inst = I_LW_X5;   chk3("lu_c0", 8'h00, 8'h00, 8'h00);  tick();
    inst = I_ADDI_X6; chk3("lu_c1", 8'hC0, 8'hC0, 8'hC0);  tick();
    chk3("lu_c2", 8'h08, 8'hC8, 8'hC8); tick();
    chk3("lu_c3", 8'h00, 8'h00, 8'hC0); tick();
    inst = I_NOP;     chk3("lu_c4", 8'h00, 8'h00, 8'h00);  tick();

    // Writes to and reads of x0 never bypass, forward or stall
    inst = I_ADDI_X0; chk3("x0_c0", 8'h00, 8'h00, 8'h00); tick();
    inst = I_ADD_X7;  chk3("x0_c1", 8'h00, 8'h00, 8'h00); tick();
    inst = I_LW_X0;   chk3("x0_c2", 8'h00, 8'h00, 8'h00); tick();
    inst = I_ADD_X8;  chk3("x0_c3", 8'h00, 8'h00, 8'h00); tick();
    inst = I_NOP;     chk3("x0_c4", 8'h00, 8'h00, 8'h00); tick();
    chk3("x0_c5", 8'h00, 8'h00, 8'h00); tick();

    // Load-use coinciding with a redirect: flush wins, FSM stays in RUN
    inst = I_LW_X5;   chk3("rd_c0", 8'h00, 8'h00, 8'h00); tick();
    inst = I_ADDI_X6; redirect = 1'b1;
    chk3("rd_flush", 8'h20, 8'h20, 8'h20); tick();
    inst = I_NOP;     redirect = 1'b0;
    chk3("rd_after", 8'h00, 8'h00, 8'h00); tick();
    chk3("rd_c3", 8'h00, 8'h00, 8'h00); tick();

    // mem_busy for 4 cycles in the middle of a load-use stall
    inst = I_NOP;
    do_reset();
    inst = I_LW_X5;   chk3("mw_c0", 8'h00, 8'h00, 8'h00); tick();
    inst = I_ADDI_X6; chk3("mw_c1", 8'hC0, 8'hC0, 8'hC0); tick();
    busy = 1'b1;
    chk3("mw_frz0", 8'h18, 8'h18, 8'h18); tick();
    chk3("mw_frz1", 8'h18, 8'h18, 8'h18); tick();
    chk3("mw_frz2", 8'h18, 8'h18, 8'h18); tick();
    chk3("mw_frz3", 8'h18, 8'h18, 8'h18); tick();
    busy = 1'b0;
    chk3("mw_resume", 8'h08, 8'hC8, 8'hC8); tick();
    chk3("mw_c7", 8'h00, 8'h00, 8'hC0); tick();
    inst = I_NOP;     chk3("mw_c8", 8'h00, 8'h00, 8'h00);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt/lu1", sc1, 32'd5);
    chk("stall_cnt/lu2", sc2, 32'd6);
    chk("stall_cnt/lu3", sc3, 32'd7);
    chk("flush_cnt/lu2", fc2, 32'd0);
`endif
    tick();

    // Reset pulsed while LU_STALL is pending
    inst = I_LW_X5;   chk3("rs_c0", 8'h00, 8'h00, 8'h00); tick();
    inst = I_ADDI_X6; chk3("rs_c1", 8'hC0, 8'hC0, 8'hC0); tick();
    do_reset();
    chk3("rs_after", 8'h00, 8'h00, 8'h00); tick();
    chk3("rs_c3", 8'h00, 8'h00, 8'h00); tick();
    inst = I_LW_X5;   chk3("rs_c4", 8'h00, 8'h00, 8'h00); tick();
    inst = I_ADDI_X6; chk3("rs_lu0", 8'hC0, 8'hC0, 8'hC0); tick();
    chk3("rs_lu1", 8'h08, 8'hC8, 8'hC8); tick();
    inst = I_NOP;
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_rst/lu3", sc3, 32'd2);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Central stall/flush/forward sequencer for the 3-stage RV32I core: s1 = fetch/decode/regread, s2 = execute/branch-resolve/dmem-address, s3 = writeback.
- Keeps its own shadow pipeline of decoded hazard info for s2 and s3, and advances it with the same stall, bubble and flush decisions it issues.
- Drives the s1 regfile-bypass selects, the s2 ALU forward selects, the load-use stall, the redirect flush and the dmem/IO freeze.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word the datapath injects on a bubble or flush; the shadow pipeline treats it as non-writing.
- LU_BUBBLES, 1, load-use bubbles inserted; legal values 1..3.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clk in 1: core clock.
- rst_n in 1: asynchronous, active-low reset.
- inst_s1 in 32: instruction currently in s1.
- valid_s1 in 1: s1 holds a real instruction.
- redirect_s2 in 1: taken branch or JALR resolved in s2 this cycle.
- mem_busy in 1: dmem/IO not ready; the whole pipe must hold.
- stall_pc out 1: hold PC and the s1 register.
- bubble_s2 out 1: load NOP_INST into s2 at the next edge.
- flush_s1 out 1: replace s1 with NOP_INST at the next edge.
- freeze out 1: hold the s1, s2 and s3 registers.
- byp_rs1_s1, byp_rs2_s1 out 1 each: 1 = s1 operand takes the s3 writeback value.
- fwd_rs1_s2, fwd_rs2_s2 out 1 each: 1 = s2 ALU operand takes the s3 result.
- stall_cnt, flush_cnt out PERF_W each: present only with the optional feature.

Behaviour:
- Decode classes:
  - writes_rd: R, I, LOAD, LUI, AUIPC, JAL, JALR, CSR.
  - reads_rs1: R, I, LOAD, STORE, BRANCH, JALR, CSRRW/CSRRS/CSRRC.
  - reads_rs2: R, STORE, BRANCH.
  - is_load: LOAD.
  - rd == x0 never creates a hazard.
- Shadow pipeline: {valid, writes_rd, is_load, rd} for s2 and s3; regfile source fields for s2. Update rules:
  - freeze: hold everything.
  - Otherwise s3 <= s2.
  - s2 <= bubble if bubble_s2, else decoded s1 (valid_s1 && !flush_s1).
- Outputs are combinational from state, shadow and inst_s1. All state is registered.
- byp_rsX_s1 = s1 reads rsX && s3 valid && writes_rd && rd_s3 == rsX && rsX != 0.
- fwd_rsX_s2 = s2 reads rsX && s3 valid && writes_rd && !is_load_s3 && rd_s3 == rsX && rsX != 0.
  - Load data never forwards into s2; that case is covered by the load-use stall plus s1 bypass.
- FSM states: RUN, LU_STALL, MEM_WAIT; a 2-bit bubble counter bcnt.
- RUN:
  - mem_busy -> MEM_WAIT; freeze = 1 in the same cycle.
  - Else redirect_s2 -> flush_s1 = 1, stay RUN. Redirect beats load-use because the consumer is flushed.
  - Else load-use (s2 valid load, rd_s2 != 0, s1 reads rd_s2) -> stall_pc = 1, bubble_s2 = 1. If LU_BUBBLES > 1: bcnt <= LU_BUBBLES-1, go to LU_STALL.
- LU_STALL: stall_pc = 1, bubble_s2 = 1, bcnt decrements; bcnt == 1 -> RUN. mem_busy overrides: freeze, bcnt held.
- MEM_WAIT:
  - freeze = 1; stall_pc, bubble_s2 and flush_s1 are 0.
  - mem_busy low -> return to the saved state (RUN or LU_STALL).
  - A redirect_s2 seen while frozen is ignored. The datapath holds redirect_s2 stable until the pipe moves.
- Reset: state RUN, bcnt 0, all shadow valid 0. Every output is 0 during and immediately after reset.
- Reset mid-stall returns to RUN with no pending bubbles.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cnt increments every cycle stall_pc or freeze is 1.
  - flush_cnt increments every cycle flush_s1 is 1.
  - Both counters wrap at 2^PERF_W and reset to 0.
- When not defined: the stall_cnt/flush_cnt ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header: OPC_* opcode defines, FSM state encodings, NOP_INST value.
- One combinational sub-module, inst_hazard_decode: 32-bit instruction -> {writes_rd, reads_rs1, reads_rs2, is_load, rd, rs1, rs2}.
  - Instantiated once for s1.
  - The shadow pipeline carries its outputs, so s2/s3 never need a re-decode.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3: cycle 2 fwd_rs1_s2 = 1, no stall.
- lw x5,0(x1) then addi x6,x5,1, LU_BUBBLES=1: exactly 1 cycle with stall_pc = bubble_s2 = 1; next cycle byp_rs1_s1 = 1. With LU_BUBBLES=3: 3 stall cycles.
- addi x0,x1,1 followed by consumers of x0: no byp, fwd or stall asserted.
- Load-use and redirect_s2 in the same cycle: flush_s1 = 1, stall_pc = 0, state stays RUN.
- mem_busy high 4 cycles mid-LU_STALL (LU_BUBBLES=2): freeze = 1 for 4 cycles, then the remaining single bubble issues; with HAZARD_PERF_CNT_EN, stall_cnt = 6.
- rst_n pulsed low during LU_STALL: all outputs 0, state RUN, shadow valids 0; the next lw/use pair stalls normally.
